zpu_wb_arbiter: RTL and testbench

Two-master round-robin arbiter for pipelined Wishbone. It shares the single slave bus between master 0 (zpu_core wb master) and master 1 (debug/DMA master). It grants the bus for the full duration of a master's `cyc`, limits outstanding strobes, and produces a synthetic ack with a timeout pulse if a slave never responds.

---
 rtl/zpu_wb_arbiter.sv | 166 ++++++++++++++++
 tb/tb_zpu_wb_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zpu_wb_arbiter.sv
// rtl/zpu_wb_arbiter.sv - two-master round-robin arbiter for pipelined Wishbone
// Holds a grant for a master's whole cyc, caps outstanding strobes, synthesises an ack on slave timeout.
module zpu_wb_arbiter #(
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_cyc,
    input  logic        m0_stb,
    input  logic        m0_we,
    input  logic [31:0] m0_adr,
    input  logic [31:0] m0_dat_o,
    input  logic [3:0]  m0_sel,
    output logic [31:0] m0_dat_i,
    output logic        m0_ack,
    output logic        m0_stall,

    input  logic        m1_cyc,
    input  logic        m1_stb,
    input  logic        m1_we,
    input  logic [31:0] m1_adr,
    input  logic [31:0] m1_dat_o,
    input  logic [3:0]  m1_sel,
    output logic [31:0] m1_dat_i,
    output logic        m1_ack,
    output logic        m1_stall,

    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    output logic [31:0] s_adr,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack,
    input  logic        s_stall,

    output logic [1:0]  grant,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t      state;
    logic        last;
    logic [2:0]  outstanding;
    logic [7:0]  tcnt;

    logic        own0;
    logic        own1;
    logic        own_cyc;
    logic        own_stb;
    logic        own_we;
    logic [31:0] own_adr;
    logic [31:0] own_dat;
    logic [3:0]  own_sel;

    logic        full;
    logic        accept;
    logic        real_ack;
    logic        synth_ack;
    logic        any_ack;

    assign own0 = (state == GNT0);
    assign own1 = (state == GNT1);

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = 32'd0;
        own_dat = 32'd0;
        own_sel = 4'd0;
        if (own0) begin
            own_cyc = m0_cyc;
            own_stb = m0_stb;
            own_we  = m0_we;
            own_adr = m0_adr;
            own_dat = m0_dat_o;
            own_sel = m0_sel;
        end else if (own1) begin
            own_cyc = m1_cyc;
            own_stb = m1_stb;
            own_we  = m1_we;
            own_adr = m1_adr;
            own_dat = m1_dat_o;
            own_sel = m1_sel;
        end
    end

    assign full     = (outstanding == 3'(MAX_OUT));
    assign s_cyc    = own_cyc;
    assign s_stb    = own_stb & ~full;
    assign s_we     = own_we;
    assign s_adr    = own_adr;
    assign s_dat_o  = own_dat;
    assign s_sel    = own_sel;

    // Acks with nothing outstanding, or outside an owned cycle, are stale and dropped.
    assign accept    = s_cyc & s_stb & ~s_stall;
    assign real_ack  = s_cyc & s_ack & (outstanding != 3'd0);
    assign synth_ack = s_cyc & (outstanding != 3'd0) & ~real_ack & ~accept
                     & (tcnt == 8'(TIMEOUT - 1));
    assign any_ack   = real_ack | synth_ack;

    assign timeout  = synth_ack;
    assign grant    = {own1, own0};

    assign m0_ack   = own0 & any_ack;
    assign m0_stall = own0 ? (s_stall | full) : 1'b1;
    assign m0_dat_i = (own0 & ~synth_ack) ? s_dat_i : 32'd0;

    assign m1_ack   = own1 & any_ack;
    assign m1_stall = own1 ? (s_stall | full) : 1'b1;
    assign m1_dat_i = (own1 & ~synth_ack) ? s_dat_i : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last        <= 1'b1;
            outstanding <= 3'd0;
            tcnt        <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (m0_cyc && (!m1_cyc || last))
                        state <= GNT0;
                    else if (m1_cyc)
                        state <= GNT1;
                end
                GNT0: begin
                    if (!m0_cyc) begin
                        state <= IDLE;
                        last  <= 1'b0;
                    end
                end
                GNT1: begin
                    if (!m1_cyc) begin
                        state <= IDLE;
                        last  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Dropping cyc abandons whatever is still in flight.
            if (state == IDLE || !own_cyc) begin
                outstanding <= 3'd0;
                tcnt        <= 8'd0;
            end else begin
                outstanding <= outstanding + {2'b00, accept} - {2'b00, any_ack};
                if (accept || any_ack || outstanding == 3'd0)
                    tcnt <= 8'd0;
                else
                    tcnt <= tcnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_zpu_wb_arbiter.sv
// tb/tb_zpu_wb_arbiter.sv - scoreboard bench for zpu_wb_arbiter
`timescale 1ns/1ps
module tb_zpu_wb_arbiter;

    localparam int MAX_OUT = 4;
    localparam int TIMEOUT = 8;

    logic        clk;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we, m0_ack, m0_stall;
    logic [31:0] m0_adr, m0_dat_o, m0_dat_i;
    logic [3:0]  m0_sel;
    logic        m1_cyc, m1_stb, m1_we, m1_ack, m1_stall;
    logic [31:0] m1_adr, m1_dat_o, m1_dat_i;
    logic [3:0]  m1_sel;
    logic        s_cyc, s_stb, s_we, s_ack, s_stall;
    logic [31:0] s_adr, s_dat_o, s_dat_i;
    logic [3:0]  s_sel;
    logic [1:0]  grant;
    logic        timeout;

    zpu_wb_arbiter #(.MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_o(m0_dat_o), .m0_sel(m0_sel), .m0_dat_i(m0_dat_i),
        .m0_ack(m0_ack), .m0_stall(m0_stall),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_o(m1_dat_o), .m1_sel(m1_sel), .m1_dat_i(m1_dat_i),
        .m1_ack(m1_ack), .m1_stall(m1_stall),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_o(s_dat_o), .s_sel(s_sel), .s_dat_i(s_dat_i),
        .s_ack(s_ack), .s_stall(s_stall),
        .grant(grant), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic we; logic [31:0] adr; logic [31:0] exp; } req_t;
    typedef struct { int due; logic [31:0] dat; } rsp_t;

    req_t        mq0[$], mq1[$];
    rsp_t        sq[$];
    logic [31:0] sb0[$], sb1[$];
    bit          hold0, hold1, s_auto;
    int          s_rel, s_acc, n_ack0, n_ack1, n_to, cyc_no;
    int          n_cmp, n_bad;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc_no);
        end
    endtask

    task automatic drive();
        rsp_t r;
        m0_cyc = hold0;
        m0_stb = hold0 && (mq0.size() > 0);
        if (m0_stb) begin
            m0_we = mq0[0].we; m0_adr = mq0[0].adr; m0_dat_o = ~mq0[0].adr; m0_sel = 4'hf;
        end else begin
            m0_we = 1'b1; m0_adr = 32'hBAD0_0000; m0_dat_o = 32'hCAFE_0000; m0_sel = 4'h5;
        end
        m1_cyc = hold1;
        m1_stb = hold1 && (mq1.size() > 0);
        if (m1_stb) begin
            m1_we = mq1[0].we; m1_adr = mq1[0].adr; m1_dat_o = ~mq1[0].adr; m1_sel = 4'h3;
        end else begin
            m1_we = 1'b1; m1_adr = 32'hBAD0_0001; m1_dat_o = 32'hCAFE_0001; m1_sel = 4'ha;
        end
        s_ack   = 1'b0;
        s_dat_i = 32'hDEAD_BEEF;
        if (sq.size() > 0 && ((s_auto && sq[0].due <= cyc_no) || s_rel > 0)) begin
            r = sq[0];
            sq.delete(0);
            s_ack   = 1'b1;
            s_dat_i = r.dat;
            if (s_rel > 0) s_rel--;
        end
    endtask

    task automatic monitor();
        if (s_cyc && s_stb && !s_stall) begin
            sq.push_back(rsp_t'{cyc_no + 2, s_adr});
            s_acc++;
        end
        if (m0_stb && !m0_stall) begin
            check_eq("fwd_adr0", s_adr, mq0[0].adr);
            sb0.push_back(mq0[0].exp);
            mq0.delete(0);
        end
        if (m1_stb && !m1_stall) begin
            check_eq("fwd_adr1", s_adr, mq1[0].adr);
            sb1.push_back(mq1[0].exp);
            mq1.delete(0);
        end
        if (m0_ack) begin
            n_ack0++;
            if (sb0.size() > 0) begin
                check_eq("m0_dat", m0_dat_i, sb0[0]);
                sb0.delete(0);
            end else check_eq("m0_spurious_ack", 32'(m0_ack), 0);
        end
        if (m1_ack) begin
            n_ack1++;
            if (sb1.size() > 0) begin
                check_eq("m1_dat", m1_dat_i, sb1[0]);
                sb1.delete(0);
            end else check_eq("m1_spurious_ack", 32'(m1_ack), 0);
        end
        if (!grant[0]) check_eq("m0_nonowner_stall", 32'(m0_stall), 1);
        if (!grant[1]) check_eq("m1_nonowner_stall", 32'(m1_stall), 1);
        if (timeout) n_to++;
    endtask

    task automatic step_chk();
        drive();
        #3;
        monitor();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc_no++;
    endtask

    task automatic step();
        step_chk();
        adv();
    endtask

    task automatic do_reset();
        rst = 1'b1; hold0 = 1'b0; hold1 = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_grant"}, 32'(grant), 0);
        check_eq({pfx, "_s_cyc"}, 32'(s_cyc), 0);
        check_eq({pfx, "_s_stb"}, 32'(s_stb), 0);
        check_eq({pfx, "_s_we"}, 32'(s_we), 0);
        check_eq({pfx, "_s_adr"}, s_adr, 0);
        check_eq({pfx, "_s_sel"}, 32'(s_sel), 0);
        check_eq({pfx, "_s_dat_o"}, s_dat_o, 0);
        check_eq({pfx, "_m0_ack"}, 32'(m0_ack), 0);
        check_eq({pfx, "_m1_ack"}, 32'(m1_ack), 0);
        check_eq({pfx, "_m0_dat_i"}, m0_dat_i, 0);
        check_eq({pfx, "_m1_dat_i"}, m1_dat_i, 0);
        check_eq({pfx, "_timeout"}, 32'(timeout), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, base, to0;
        n_cmp = 0; n_bad = 0; cyc_no = 0; s_rel = 0; s_acc = 0;
        n_ack0 = 0; n_ack1 = 0; n_to = 0; s_auto = 1'b0; s_stall = 1'b0;
        hold0 = 1'b0; hold1 = 1'b0; rst = 1'b1;
        drive();
        @(posedge clk); #1;
        step();
        step();
        rst = 1'b0;

        // reset state, with a stray slave ack while idle
        sq.push_back(rsp_t'{0, 32'h0000_1234});
        s_rel = 1;
        step_chk();
        check_eq("t0_s_ack_driven", 32'(s_ack), 1);
        check_reset_outputs("t0");
        adv();

        // single master: three pipelined reads, slave acks two cycles after each strobe
        mq0.push_back(req_t'{1'b0, 32'h11, 32'h11});
        mq0.push_back(req_t'{1'b0, 32'h22, 32'h22});
        mq0.push_back(req_t'{1'b0, 32'h33, 32'h33});
        s_auto = 1'b1; hold0 = 1'b1; a0 = n_ack0;
        step_chk();
        check_eq("t1_grant_latency", 32'(grant), 0);
        adv();
        s_stall = 1'b1;
        step_chk();
        check_eq("t1_grant", 32'(grant), 1);
        check_eq("t1_first_stb", 32'(s_stb), 1);
        check_eq("t1_first_adr", s_adr, 32'h11);
        check_eq("t1_slave_stall_fwd", 32'(m0_stall), 1);
        adv();
        s_stall = 1'b0;
        for (int k = 0; k < 20 && (mq0.size() > 0 || sb0.size() > 0); k++) begin
            step_chk();
            check_eq("t1_grant_hold", 32'(grant), 1);
            check_eq("t1_m1_stall", 32'(m1_stall), 1);
            check_eq("t1_m1_dat_i", m1_dat_i, 0);
            adv();
        end
        check_eq("t1_acks", 32'(n_ack0 - a0), 3);
        hold0 = 1'b0;
        step_chk();
        check_eq("t1_release_grant", 32'(grant), 1);
        check_eq("t1_release_s_cyc", 32'(s_cyc), 0);
        adv();
        step_chk();
        check_eq("t1_idle", 32'(grant), 0);
        adv();

        // contention after reset: m0 first, one idle cycle, then m1; repeat gives m0
        do_reset();
        hold0 = 1'b1; hold1 = 1'b1;
        step_chk(); check_eq("t2_idle0", 32'(grant), 0); adv();
        step_chk(); check_eq("t2_m0_first", 32'(grant), 1); adv();
        hold0 = 1'b0;
        step_chk(); check_eq("t2_m0_drop", 32'(grant), 1); adv();
        step_chk();
        check_eq("t2_gap", 32'(grant), 0);
        check_eq("t2_gap_s_cyc", 32'(s_cyc), 0);
        adv();
        step_chk();
        check_eq("t2_m1_next", 32'(grant), 2);
        check_eq("t2_m1_s_cyc", 32'(s_cyc), 1);
        adv();
        hold1 = 1'b0;
        step();
        hold0 = 1'b1; hold1 = 1'b1;
        step_chk(); check_eq("t2_idle1", 32'(grant), 0); adv();
        step_chk(); check_eq("t2_rr_m0", 32'(grant), 1); adv();
        hold0 = 1'b0;
        step();
        step_chk(); check_eq("t2_idle2", 32'(grant), 0); adv();
        step_chk(); check_eq("t2_rr_m1", 32'(grant), 2); adv();
        hold1 = 1'b0;
        step(); step();

        // outstanding limit: six strobes from m1, slave holds acks
        s_auto = 1'b0;
        for (int i = 0; i < 6; i++)
            mq1.push_back(req_t'{1'b0, 32'h100 + 32'(4 * i), 32'h100 + 32'(4 * i)});
        hold1 = 1'b1; base = s_acc;
        repeat (5) step();
        step_chk();
        check_eq("t3_acc_max", 32'(s_acc - base), 4);
        check_eq("t3_full_stall", 32'(m1_stall), 1);
        check_eq("t3_full_no_stb", 32'(s_stb), 0);
        adv();
        s_rel = 1;
        step_chk(); check_eq("t3_one_ack", 32'(m1_ack), 1); adv();
        step_chk();
        check_eq("t3_released_stb", 32'(s_stb), 1);
        check_eq("t3_released_stall", 32'(m1_stall), 0);
        adv();
        step_chk();
        check_eq("t3_acc_plus_one", 32'(s_acc - base), 5);
        check_eq("t3_full_again", 32'(m1_stall), 1);
        adv();
        s_auto = 1'b1;
        for (int k = 0; k < 30 && (mq1.size() > 0 || sb1.size() > 0); k++) step();
        check_eq("t3_drained", 32'(mq1.size() + sb1.size()), 0);
        check_eq("t3_no_timeout", 32'(n_to), 0);
        hold1 = 1'b0;
        step(); step();

        // timeout: one write, slave never acks
        s_auto = 1'b0; to0 = n_to;
        mq0.push_back(req_t'{1'b1, 32'h200, 32'h0});
        hold0 = 1'b1;
        step();
        step_chk();
        check_eq("t4_accept", 32'(s_stb && !s_stall), 1);
        check_eq("t4_we", 32'(s_we), 1);
        adv();
        for (int k = 1; k <= TIMEOUT; k++) begin
            step_chk();
            check_eq($sformatf("t4_ack_c%0d", k), 32'(m0_ack), 32'(k == TIMEOUT));
            check_eq($sformatf("t4_pulse_c%0d", k), 32'(timeout), 32'(k == TIMEOUT));
            adv();
        end
        s_rel = 1;
        step_chk();
        check_eq("t4_late_ack_ignored", 32'(m0_ack), 0);
        adv();
        repeat (10) step();
        check_eq("t4_single_pulse", 32'(n_to - to0), 1);
        hold0 = 1'b0;
        step(); step();
        sq.delete();

        // abort with two outstanding, late ack lands while m1 is granted
        s_auto = 1'b0;
        mq0.push_back(req_t'{1'b0, 32'h300, 32'h300});
        mq0.push_back(req_t'{1'b0, 32'h304, 32'h304});
        hold0 = 1'b1;
        step(); step(); step();
        check_eq("t5_two_out", 32'(sb0.size()), 2);
        sb0.delete();
        hold0 = 1'b0; hold1 = 1'b1; a1 = n_ack1;
        mq1.push_back(req_t'{1'b0, 32'h400, 32'h400});
        step();
        step_chk(); check_eq("t5_idle", 32'(grant), 0); adv();
        s_rel = 1;
        step_chk();
        check_eq("t5_grant_m1", 32'(grant), 2);
        check_eq("t5_late_ack_seen", 32'(s_ack), 1);
        check_eq("t5_late_m1", 32'(m1_ack), 0);
        check_eq("t5_late_m0", 32'(m0_ack), 0);
        adv();
        sq.delete(0);
        s_auto = 1'b1;
        for (int k = 0; k < 10 && sb1.size() > 0; k++) step();
        check_eq("t5_m1_real_ack", 32'(n_ack1 - a1), 1);
        hold1 = 1'b0;
        step(); step();

        // reset mid-grant during an m1 burst
        s_auto = 1'b1;
        for (int i = 0; i < 4; i++)
            mq1.push_back(req_t'{1'b0, 32'h500 + 32'(4 * i), 32'h500 + 32'(4 * i)});
        hold1 = 1'b1;
        step(); step(); step();
        rst = 1'b1;
        step_chk(); check_eq("t6_pre_rst_grant", 32'(grant), 2); adv();
        rst = 1'b0;
        sb1.delete(); mq1.delete();
        hold0 = 1'b1;
        step_chk();
        check_reset_outputs("t6");
        check_eq("t6_m0_stall", 32'(m0_stall), 1);
        check_eq("t6_m1_stall", 32'(m1_stall), 1);
        adv();
        sq.delete();
        step_chk(); check_eq("t6_tie_m0", 32'(grant), 1); adv();
        hold0 = 1'b0; hold1 = 1'b0;
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
